// File: rtl/mdu_unit.sv
// Multi-cycle multiply/divide unit with HI/LO registers for the EX stage.
// Results are computed at issue into a pending register and committed after the busy window.
module mdu_unit #(
  parameter int unsigned MultCycles = 5,
  parameter int unsigned DivCycles  = 10
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        start_i,
  input  logic [3:0]  md_op_i,
  input  logic [31:0] operand1_i,
  input  logic [31:0] operand2_i,
  input  logic        flush_i,
  output logic        busy_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic [31:0] rdata_o
);

  localparam int unsigned MaxCycles = (MultCycles > DivCycles) ? MultCycles : DivCycles;
  localparam int unsigned CntW      = (MaxCycles > 1) ? $clog2(MaxCycles) : 1;

  localparam logic [3:0] OpMult  = 4'd1;
  localparam logic [3:0] OpMultu = 4'd2;
  localparam logic [3:0] OpDiv   = 4'd3;
  localparam logic [3:0] OpDivu  = 4'd4;
  localparam logic [3:0] OpMfhi  = 4'd5;
  localparam logic [3:0] OpMthi  = 4'd7;
  localparam logic [3:0] OpMtlo  = 4'd8;

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  state_e            state_q;
  logic [CntW-1:0]   cnt_q;
  logic [63:0]       pend_q;
  logic              pend_wr_q;
  logic [31:0]       hi_q, lo_q;

  logic signed [63:0] prod_s;
  logic [63:0]        prod_u;
  logic [31:0]        a_mag, b_mag, b_div, q_mag, r_mag;
  logic [31:0]        q_s, r_s, q_u, r_u;
  logic [63:0]        result;
  logic               div_zero;

  always_comb begin
    prod_s = $signed({{32{operand1_i[31]}}, operand1_i}) *
             $signed({{32{operand2_i[31]}}, operand2_i});
    prod_u = {32'd0, operand1_i} * {32'd0, operand2_i};
    div_zero = (operand2_i == 32'd0);
    b_div    = div_zero ? 32'd1 : operand2_i;
    // Signed divide on magnitudes avoids the 0x80000000 / -1 overflow corner.
    a_mag = operand1_i[31] ? (~operand1_i + 32'd1) : operand1_i;
    b_mag = b_div[31] ? (~b_div + 32'd1) : b_div;
    q_mag = a_mag / b_mag;
    r_mag = a_mag % b_mag;
    q_s   = (operand1_i[31] ^ b_div[31]) ? (~q_mag + 32'd1) : q_mag;
    r_s   = operand1_i[31] ? (~r_mag + 32'd1) : r_mag;
    q_u   = operand1_i / b_div;
    r_u   = operand1_i % b_div;
    case (md_op_i)
      OpMult:  result = prod_s;
      OpMultu: result = prod_u;
      OpDiv:   result = {r_s, q_s};
      default: result = {r_u, q_u};
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      pend_q    <= '0;
      pend_wr_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else if (flush_i) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (start_i) begin
            case (md_op_i)
              OpMult, OpMultu: begin
                state_q   <= StBusy;
                cnt_q     <= CntW'(MultCycles - 1);
                pend_q    <= result;
                pend_wr_q <= 1'b1;
              end
              OpDiv, OpDivu: begin
                state_q   <= StBusy;
                cnt_q     <= CntW'(DivCycles - 1);
                pend_q    <= result;
                pend_wr_q <= !div_zero;
              end
              OpMthi:  hi_q <= operand1_i;
              OpMtlo:  lo_q <= operand1_i;
              default: ;
            endcase
          end
        end
        StBusy: begin
          if (cnt_q == '0) begin
            state_q <= StIdle;
            if (pend_wr_q) begin
              hi_q <= pend_q[63:32];
              lo_q <= pend_q[31:0];
            end
          end else begin
            cnt_q <= cnt_q - CntW'(1);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy_o  = (state_q == StBusy);
  assign hi_o    = hi_q;
  assign lo_o    = lo_q;
  assign rdata_o = (md_op_i == OpMfhi) ? hi_q : lo_q;

endmodule

// File: tb/tb_mdu_unit.sv
// Directed plus randomized bench for mdu_unit against an arithmetic HI/LO reference model.
module tb_mdu_unit;

  localparam int unsigned MC = 5;
  localparam int unsigned DC = 10;

  logic        clk, rst_n, start, flush;
  logic [3:0]  md_op;
  logic [31:0] operand1, operand2;
  logic        busy;
  logic [31:0] hi, lo, rdata;

  logic [31:0] hi_m, lo_m;
  int          n_vec, n_err;

  mdu_unit #(.MultCycles(MC), .DivCycles(DC)) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .start_i    (start),
    .md_op_i    (md_op),
    .operand1_i (operand1),
    .operand2_i (operand2),
    .flush_i    (flush),
    .busy_o     (busy),
    .hi_o       (hi),
    .lo_o       (lo),
    .rdata_o    (rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one op, update the model, then measure the busy window and check HI/LO.
  task automatic run_md(input string tag, input logic [3:0] op,
                        input logic [31:0] a, input logic [31:0] b);
    int     cyc, n;
    longint sa, sb, p;
    logic [63:0] pu;
    @(negedge clk);
    start = 1'b1; md_op = op; operand1 = a; operand2 = b;
    @(negedge clk);
    start = 1'b0; md_op = 4'd0;
    n = 0;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      4'd1: begin p = sa * sb; {hi_m, lo_m} = p; n = MC; end
      4'd2: begin pu = {32'd0, a} * {32'd0, b}; {hi_m, lo_m} = pu; n = MC; end
      4'd3: begin
        n = DC;
        if (b != 0) begin lo_m = 32'(sa / sb); hi_m = 32'(sa % sb); end
      end
      4'd4: begin
        n = DC;
        if (b != 0) begin lo_m = a / b; hi_m = a % b; end
      end
      4'd7: hi_m = a;
      4'd8: lo_m = a;
      default: ;
    endcase
    cyc = 0;
    while (busy === 1'b1 && cyc < 64) begin
      cyc++;
      @(negedge clk);
    end
    chk({tag, "_busy_len"}, 32'(cyc), 32'(n));
    chk({tag, "_hi"}, hi, hi_m);
    chk({tag, "_lo"}, lo, lo_m);
  endtask

  task automatic read_chk(input string tag, input logic [3:0] op);
    @(negedge clk);
    start = 1'b1; md_op = op;
    #1;
    chk({tag, "_rdata"}, rdata, (op == 4'd5) ? hi_m : lo_m);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    @(negedge clk);
    start = 1'b0; md_op = 4'd0;
  endtask

  initial begin
    logic [3:0]  op;
    logic [31:0] a, b;
    n_vec = 0; n_err = 0;
    rst_n = 1'b0; start = 1'b0; flush = 1'b0; md_op = 4'd0;
    operand1 = '0; operand2 = '0;
    hi_m = '0; lo_m = '0;
    repeat (2) @(negedge clk);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_hi", hi, 32'd0);
    chk("reset_lo", lo, 32'd0);
    chk("reset_rdata", rdata, 32'd0);
    rst_n = 1'b1;

    run_md("mult", 4'd1, 32'hFFFFFFFE, 32'h3);
    run_md("multu", 4'd2, 32'hFFFFFFFE, 32'h3);
    run_md("div", 4'd3, 32'hFFFFFFF9, 32'h2);
    run_md("divu", 4'd4, 32'hFFFFFFF9, 32'h2);

    run_md("mthi", 4'd7, 32'h11, 32'h0);
    run_md("mtlo", 4'd8, 32'h22, 32'h0);
    run_md("div0", 4'd3, 32'h1234, 32'h0);
    run_md("divovf", 4'd3, 32'h80000000, 32'hFFFFFFFF);

    run_md("mthi2", 4'd7, 32'hDEADBEEF, 32'h0);
    read_chk("mfhi", 4'd5);
    read_chk("mflo", 4'd6);

    // start with flush: must not go busy or write HI/LO
    @(negedge clk);
    start = 1'b1; md_op = 4'd1; operand1 = 32'h7; operand2 = 32'h9; flush = 1'b1;
    @(negedge clk);
    md_op = 4'd7;
    @(negedge clk);
    start = 1'b0; md_op = 4'd0; flush = 1'b0;
    chk("flush_start_busy", {31'd0, busy}, 32'd0);
    chk("flush_start_hi", hi, hi_m);
    chk("flush_start_lo", lo, lo_m);

    // flush during the third busy cycle of a MULT
    @(negedge clk);
    start = 1'b1; md_op = 4'd1; operand1 = 32'h1000; operand2 = 32'h1000;
    @(negedge clk);
    start = 1'b0; md_op = 4'd0;
    @(negedge clk);
    @(negedge clk);
    chk("flush_mid_busy_before", {31'd0, busy}, 32'd1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_mid_busy", {31'd0, busy}, 32'd0);
    repeat (MC + 2) @(negedge clk);
    chk("flush_mid_hi", hi, hi_m);
    chk("flush_mid_lo", lo, lo_m);
    run_md("divu_after_flush", 4'd4, 32'd1000003, 32'd97);

    for (int i = 0; i < 60; i++) begin
      op = 4'($urandom_range(1, 8));
      a  = $urandom;
      b  = $urandom;
      if ($urandom_range(0, 3) == 0) b = 32'd0;
      else if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(1, 20));
      if (op == 4'd5 || op == 4'd6) read_chk("rand_rd", op);
      else run_md("rand", op, a, b);
    end

    // asynchronous reset in the middle of a DIV
    run_md("pre_reset", 4'd1, 32'h12345, 32'h6789);
    @(negedge clk);
    start = 1'b1; md_op = 4'd3; operand1 = 32'h99999; operand2 = 32'h7;
    @(negedge clk);
    start = 1'b0; md_op = 4'd0;
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_busy", {31'd0, busy}, 32'd0);
    chk("async_rst_hi", hi, 32'd0);
    chk("async_rst_lo", lo, 32'd0);
    hi_m = '0; lo_m = '0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (DC + 2) @(negedge clk);
    chk("post_rst_busy", {31'd0, busy}, 32'd0);
    chk("post_rst_hi", hi, 32'd0);
    run_md("post_rst_mult", 4'd1, 32'h80000000, 32'h80000000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
